// File: rtl/cc_cond_unit.sv
// Y86-64 condition-code register with NQ registered jXX/cmovXX condition query ports (1-cycle latency).
// Defining CC_UNSIGNED_EN adds CF (cc[3]) and the unsigned conditions on ifun 7-10.
module cc_cond_unit #(
   parameter int WIDTH  = 64,
   parameter int NQ     = 2,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              set_cc,
   input  logic              cc_block,
   input  logic [1:0]        alu_op,
   input  logic [WIDTH-1:0]  alu_a,
   input  logic [WIDTH-1:0]  alu_b,
   input  logic [WIDTH-1:0]  alu_res,
   input  logic [NQ-1:0]     q_valid,
   input  logic [4*NQ-1:0]   q_ifun,
   output logic [NQ-1:0]     cnd,
   output logic [NQ-1:0]     cnd_valid,
   output logic [NQ-1:0]     cnd_err,
   output logic [3:0]        cc
);

   localparam logic [1:0] OP_ADD = 2'd0;
   localparam logic [1:0] OP_SUB = 2'd1;

   logic a_msb, b_msb, r_msb;
   logic sf_new, zf_new, of_new;
   logic sf_q, zf_q, of_q;
   logic upd, byp;
   logic eff_sf, eff_zf, eff_of;
   logic [NQ-1:0] cnd_d, err_d;

   assign a_msb  = alu_a[WIDTH-1];
   assign b_msb  = alu_b[WIDTH-1];
   assign r_msb  = alu_res[WIDTH-1];
   assign sf_new = r_msb;
   assign zf_new = (alu_res == '0);

   always_comb begin
      of_new = 1'b0;
      case (alu_op)
         OP_ADD:  of_new = (a_msb == b_msb) && (r_msb != a_msb);
         OP_SUB:  of_new = (a_msb != b_msb) && (r_msb != b_msb);
         default: of_new = 1'b0;
      endcase
   end

   assign upd    = set_cc && !cc_block;
   assign byp    = (BYPASS != 0) && upd;
   assign eff_sf = byp ? sf_new : sf_q;
   assign eff_zf = byp ? zf_new : zf_q;
   assign eff_of = byp ? of_new : of_q;

`ifdef CC_UNSIGNED_EN
   logic [WIDTH:0] sum_ext;
   logic cf_new, cf_q, eff_cf;

   assign sum_ext = {1'b0, alu_b} + {1'b0, alu_a};

   always_comb begin
      cf_new = 1'b0;
      case (alu_op)
         OP_ADD:  cf_new = sum_ext[WIDTH];
         OP_SUB:  cf_new = (alu_b < alu_a);
         default: cf_new = 1'b0;
      endcase
   end

   assign eff_cf = byp ? cf_new : cf_q;

   always_ff @(posedge clk) begin
      if (rst)
         cf_q <= 1'b0;
      else if (!stall && upd)
         cf_q <= cf_new;
   end
`else
   // Only the sign bits of the operands matter without CF.
   logic cf_q;
   logic unused_ops;
   assign cf_q       = 1'b0;
   assign unused_ops = ^{alu_a[WIDTH-2:0], alu_b[WIDTH-2:0]};
`endif

   always_comb begin
      cnd_d = '0;
      err_d = '0;
      for (int i = 0; i < NQ; i++) begin
         if (q_valid[i]) begin
            case (q_ifun[4*i +: 4])
               4'd0: cnd_d[i] = 1'b1;
               4'd1: cnd_d[i] = (eff_sf ^ eff_of) | eff_zf;
               4'd2: cnd_d[i] = eff_sf ^ eff_of;
               4'd3: cnd_d[i] = eff_zf;
               4'd4: cnd_d[i] = ~eff_zf;
               4'd5: cnd_d[i] = ~(eff_sf ^ eff_of);
               4'd6: cnd_d[i] = ~(eff_sf ^ eff_of) & ~eff_zf;
`ifdef CC_UNSIGNED_EN
               4'd7:  cnd_d[i] = eff_cf;
               4'd8:  cnd_d[i] = eff_cf | eff_zf;
               4'd9:  cnd_d[i] = ~eff_cf & ~eff_zf;
               4'd10: cnd_d[i] = ~eff_cf;
`endif
               default: err_d[i] = 1'b1;
            endcase
         end
      end
   end

   // Stall freezes everything and drops the pending CC write; reset still wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         sf_q      <= 1'b0;
         zf_q      <= 1'b1;
         of_q      <= 1'b0;
         cnd       <= '0;
         cnd_valid <= '0;
         cnd_err   <= '0;
      end else if (!stall) begin
         if (upd) begin
            sf_q <= sf_new;
            zf_q <= zf_new;
            of_q <= of_new;
         end
         cnd       <= cnd_d;
         cnd_valid <= q_valid;
         cnd_err   <= err_d;
      end
   end

   assign cc = {cf_q, sf_q, zf_q, of_q};

endmodule

// File: tb/tb_cc_cond_unit.sv
// Bench for cc_cond_unit: directed vectors, scoreboard queue checked by a negedge monitor.
module tb_cc_cond_unit;
   localparam int W = 64;
   localparam logic [W-1:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [W-1:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [W-1:0] M2   = 64'hFFFF_FFFF_FFFF_FFFE;
   localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;

   logic clk = 1'b0;
   logic rst, stall, set_cc, cc_block;
   logic [1:0] alu_op;
   logic [W-1:0] alu_a, alu_b, alu_res;
   logic [1:0] q_valid;
   logic [7:0] q_ifun;
   logic [1:0] cnd1, cv1, ce1, cnd0, cv0, ce0;
   logic [3:0] cc1, cc0;

   always #5 clk = ~clk;

   cc_cond_unit #(.WIDTH(W), .NQ(2), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .stall(stall), .set_cc(set_cc), .cc_block(cc_block),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
      .q_valid(q_valid), .q_ifun(q_ifun),
      .cnd(cnd1), .cnd_valid(cv1), .cnd_err(ce1), .cc(cc1));

   cc_cond_unit #(.WIDTH(W), .NQ(2), .BYPASS(0)) dut_nobyp (
      .clk(clk), .rst(rst), .stall(stall), .set_cc(set_cc), .cc_block(cc_block),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_res(alu_res),
      .q_valid(q_valid), .q_ifun(q_ifun),
      .cnd(cnd0), .cnd_valid(cv0), .cnd_err(ce0), .cc(cc0));

   typedef struct packed {
      logic [1:0] v;
      logic [1:0] c;
      logic [1:0] e;
      logic [1:0] c0;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drv(input logic s, input logic blk, input logic st, input logic [1:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                      input logic [1:0] qv, input logic [3:0] f0, input logic [3:0] f1);
      set_cc = s; cc_block = blk; stall = st; alu_op = op;
      alu_a = a; alu_b = b; alu_res = r;
      q_valid = qv; q_ifun = {f1, f0};
   endtask

   task automatic push(input logic [1:0] v, input logic [1:0] c, input logic [1:0] e, input logic [1:0] c0);
      exp_t x;
      x.v = v; x.c = c; x.e = e; x.c0 = c0;
      sb.push_back(x);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cc(input string name, input logic [3:0] exp);
      chk({name, "_cc"}, {4'h0, cc1}, {4'h0, exp});
      chk({name, "_cc_nobyp"}, {4'h0, cc0}, {4'h0, exp});
   endtask

   always @(negedge clk) begin
      if (mon_en && (cv1 != 2'b00 || cv0 != 2'b00)) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", {cv1, cnd1, cv0, cnd0}, 8'h00);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("cnd_valid", {4'h0, cv1, cv0}, {4'h0, e.v, e.v});
            chk("cnd", {6'h0, cnd1}, {6'h0, e.c});
            chk("cnd_err", {4'h0, ce1, ce0}, {4'h0, e.e, e.e});
            chk("cnd_nobyp", {6'h0, cnd0}, {6'h0, e.c0});
         end
      end
   end

   initial begin
      rst = 1'b1;
      drv(0, 0, 0, 2'd0, '0, '0, '0, 2'b00, 4'd0, 4'd0);
      tick();
      chk_cc("reset", 4'b0010);
      chk("reset_outs", {2'b00, cv1, cnd1, ce1}, 8'h00);
      tick();
      rst = 1'b0;
      mon_en = 1'b1;

      // reset flags: e -> 1, always -> 1
      drv(0, 0, 0, 2'd0, '0, '0, '0, 2'b11, 4'd3, 4'd0);
      push(2'b11, 2'b11, 2'b00, 2'b11);
      tick();

      // add overflow: SF=1 OF=1
      drv(1, 0, 0, 2'd0, MAXP, MAXP, M2, 2'b00, 4'd0, 4'd0);
      tick();
      chk_cc("add_ovf", 4'b0101);
      drv(0, 0, 0, 2'd0, '0, '0, '0, 2'b11, 4'd2, 4'd6);
      push(2'b11, 2'b10, 2'b00, 2'b10);
      tick();

      // sub equal: ZF=1
      drv(1, 0, 0, 2'd1, 64'd1, 64'd1, '0, 2'b00, 4'd0, 4'd0);
      tick();
      chk_cc("sub_eq", 4'b0010);
      drv(0, 0, 0, 2'd0, '0, '0, '0, 2'b11, 4'd4, 4'd5);
      push(2'b11, 2'b10, 2'b00, 2'b10);
      tick();

      // invalid port carries an undefined ifun but must report nothing
      drv(0, 0, 0, 2'd0, '0, '0, '0, 2'b01, 4'd0, 4'd9);
      push(2'b01, 2'b01, 2'b00, 2'b01);
      tick();

      drv(1, 0, 0, 2'd3, '0, '0, 64'd5, 2'b00, 4'd0, 4'd0);
      tick();
      chk_cc("xor_clear", 4'b0000);

      // same-cycle write and query: bypass sees ZF=1, no-bypass sees ZF=0
      drv(1, 0, 0, 2'd2, '0, '0, '0, 2'b11, 4'd3, 4'd4);
      push(2'b11, 2'b01, 2'b00, 2'b10);
      tick();
      chk_cc("bypass_write", 4'b0010);

      drv(0, 0, 0, 2'd0, '0, '0, '0, 2'b00, 4'd0, 4'd0);
      tick();

      // stall with idle outputs: nothing may change
      drv(1, 0, 1, 2'd0, '0, ALL1, ALL1, 2'b11, 4'd0, 4'd0);
      tick();
      chk_cc("stall", 4'b0010);
      chk("stall_cnd_valid", {4'h0, cv1, cv0}, 8'h00);

      drv(0, 0, 0, 2'd0, '0, '0, '0, 2'b11, 4'd0, 4'd3);
      push(2'b11, 2'b11, 2'b00, 2'b11);
      tick();
      // stall with valid outputs: previous result held
      drv(0, 0, 1, 2'd0, '0, '0, '0, 2'b01, 4'd4, 4'd4);
      push(2'b11, 2'b11, 2'b00, 2'b11);
      tick();

      // cc_block: no write, no bypass
      drv(1, 1, 0, 2'd0, '0, ALL1, ALL1, 2'b11, 4'd3, 4'd0);
      push(2'b11, 2'b11, 2'b00, 2'b11);
      tick();
      chk_cc("cc_block", 4'b0010);

      // sub a=5 b=3: SF=1, borrow; query ifun 7 and 15
      drv(1, 0, 0, 2'd1, 64'd5, 64'd3, M2, 2'b11, 4'd7, 4'd15);
`ifdef CC_UNSIGNED_EN
      push(2'b11, 2'b01, 2'b10, 2'b00);
`else
      push(2'b11, 2'b00, 2'b11, 2'b00);
`endif
      tick();
`ifdef CC_UNSIGNED_EN
      chk_cc("sub_borrow", 4'b1100);
`else
      chk_cc("sub_borrow", 4'b0100);
`endif
      drv(0, 0, 0, 2'd0, '0, '0, '0, 2'b11, 4'd1, 4'd5);
      push(2'b11, 2'b01, 2'b00, 2'b01);
      tick();

      // sub overflow: b=MIN, a=1 -> OF=1, SF=0
      drv(1, 0, 0, 2'd1, 64'd1, MINN, MAXP, 2'b00, 4'd0, 4'd0);
      tick();
      chk_cc("sub_ovf", 4'b0001);
      drv(0, 0, 0, 2'd0, '0, '0, '0, 2'b11, 4'd2, 4'd1);
      push(2'b11, 2'b11, 2'b00, 2'b11);
      tick();

      // reset during stall
      rst = 1'b1;
      drv(0, 0, 1, 2'd0, '0, '0, '0, 2'b11, 4'd0, 4'd0);
      tick();
      chk_cc("rst_stall", 4'b0010);
      chk("rst_stall_outs", {2'b00, cv1, cnd1, ce1}, 8'h00);
      rst = 1'b0;
      drv(0, 0, 0, 2'd0, '0, '0, '0, 2'b00, 4'd0, 4'd0);
      tick();
      tick();
      chk("sb_drained", sb.size(), 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
